// File: rtl/ram32x8_pkg.sv
// Shared types and defaults for the 32x8 distributed-RAM controller.
package ram32x8_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 8;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_FILL = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        FILL_SETUP,
        FILL_PULSE,
        FILL_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SETUP,
        SEQ_PULSE,
        SEQ_HOLD
    } seq_t;

endpackage

// File: rtl/ram32x8_wr_seq.sv
// Three-phase setup/pulse/hold write-enable sequencer for level-sensitive RAM cells.
// A start in IDLE or HOLD begins a new word; ram_we is high only during PULSE.
module ram32x8_wr_seq
    import ram32x8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ram_we
);

    seq_t phase;
    seq_t phase_nxt;

    // Phase advance: SETUP and PULSE last exactly one cycle each.
    always_comb begin
        phase_nxt = phase;
        case (phase)
            SEQ_IDLE:  phase_nxt = start ? SEQ_SETUP : SEQ_IDLE;
            SEQ_SETUP: phase_nxt = SEQ_PULSE;
            SEQ_PULSE: phase_nxt = SEQ_HOLD;
            SEQ_HOLD:  phase_nxt = start ? SEQ_SETUP : SEQ_IDLE;
            default:   phase_nxt = SEQ_IDLE;
        endcase
    end

    // ram_we comes straight from a flop so it cannot glitch; reset drops it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= SEQ_IDLE;
            ram_we <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            ram_we <= (phase_nxt == SEQ_PULSE);
        end
    end

endmodule

// File: rtl/ram32x8_ctrl.sv
// Host-facing controller for a 32x8 distributed RAM: handshake, read capture,
// single writes and whole-array fill using the shared write sequencer.
module ram32x8_ctrl
    import ram32x8_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    input  logic [DW-1:0] ram_o
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] a_nxt;
    logic [DW-1:0] d_nxt;
    logic          rsp_valid_nxt;
    logic [DW-1:0] rsp_data_nxt;
    logic          seq_start;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next state plus next values for every registered RAM/response output.
    always_comb begin
        state_nxt     = state;
        a_nxt         = ram_a;
        d_nxt         = ram_d;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        seq_start     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (op_t'(req_op))
                        OP_RD: begin
                            a_nxt     = req_addr;
                            state_nxt = RD;
                        end
                        OP_WR: begin
                            a_nxt     = req_addr;
                            d_nxt     = req_data;
                            seq_start = 1'b1;
                            state_nxt = WR_SETUP;
                        end
                        OP_FILL: begin
                            a_nxt     = '0;
                            d_nxt     = req_data;
                            seq_start = 1'b1;
                            state_nxt = FILL_SETUP;
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            RD: begin
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = ram_o;
                state_nxt     = IDLE;
            end
            WR_SETUP:   state_nxt = WR_PULSE;
            WR_PULSE:   state_nxt = WR_HOLD;
            WR_HOLD:    state_nxt = IDLE;
            FILL_SETUP: state_nxt = FILL_PULSE;
            FILL_PULSE: state_nxt = FILL_HOLD;
            FILL_HOLD: begin
                if (ram_a == '1) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = ram_d;
                    state_nxt     = IDLE;
                end else begin
                    a_nxt     = ram_a + AW'(1);
                    seq_start = 1'b1;
                    state_nxt = FILL_SETUP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, RAM address/data and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ram_a     <= '0;
            ram_d     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            ram_a     <= a_nxt;
            ram_d     <= d_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    ram32x8_wr_seq u_wr_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (seq_start),
        .ram_we (ram_we)
    );

endmodule

// File: tb/tb_ram32x8_ctrl.sv
// Self-checking bench for ram32x8_ctrl with a level-sensitive 32x8 RAM model.
module tb_ram32x8_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [4:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       ram_we;
    logic [4:0] ram_a;
    logic [7:0] ram_d;
    logic [7:0] ram_o;

    int n_cmp = 0;
    int n_bad = 0;

    ram32x8_ctrl #(.AW(5), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_o     (ram_o)
    );

    always #5 clk = ~clk;

    // Behavioural level-sensitive RAM: transparent write while ram_we is high.
    logic [7:0] mem [32];
    always @(ram_we or ram_a or ram_d) if (ram_we) mem[ram_a] = ram_d;
    assign ram_o = mem[ram_a];

    // Write-pulse monitor: count pulses, log their addresses, flag pulses wider than one cycle.
    int         we_cnt = 0;
    int         width_err = 0;
    logic [4:0] we_addrs[$];
    logic       prev_we = 1'b0;
    always @(posedge ram_we) begin
        we_cnt++;
        we_addrs.push_back(ram_a);
    end
    always @(negedge clk) begin
        if (ram_we && prev_we) width_err++;
        prev_we = ram_we;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a request at a negedge once ready, hold it through the accepting edge, then drop it.
    task automatic start_req(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d);
        int guard = 0;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                           output int busy_cyc, output logic got_rsp,
                           output logic [7:0] got_data, output int pulses);
        int we0;
        int guard = 0;
        we0 = we_cnt;
        start_req(op, a, d);
        busy_cyc = 0;
        while (busy && guard < 300) begin
            busy_cyc++;
            @(negedge clk);
            guard++;
        end
        if (busy) chk("busy_timeout", 32'(busy), 32'd0);
        got_rsp  = rsp_valid;
        got_data = rsp_data;
        pulses   = we_cnt - we0;
    endtask

    task automatic do_read(input string nm, input logic [4:0] a, input logic [7:0] exp);
        int bc;
        int wp;
        logic gr;
        logic [7:0] gd;
        run_txn(2'b00, a, 8'h00, bc, gr, gd, wp);
        chk({nm, "_valid"}, 32'(gr), 32'd1);
        chk({nm, "_data"}, 32'(gd), 32'(exp));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [4:0] a;
        logic [7:0] d;
        int         busy;
        logic       rsp;
        logic [7:0] rdata;
        int         we;
    } vec_t;

    vec_t vt[9];

    initial begin
        int         bc;
        int         wp;
        logic       gr;
        logic [7:0] gd;
        int         guard;
        logic       order_ok;

        vt[0] = '{2'b00, 5'd5,  8'h00, 1,  1'b1, 8'hA5, 0};
        vt[1] = '{2'b11, 5'd0,  8'h00, 0,  1'b0, 8'h00, 0};
        vt[2] = '{2'b10, 5'd17, 8'h3C, 96, 1'b1, 8'h3C, 32};
        vt[3] = '{2'b00, 5'd0,  8'h00, 1,  1'b1, 8'h3C, 0};
        vt[4] = '{2'b00, 5'd31, 8'h00, 1,  1'b1, 8'h3C, 0};
        vt[5] = '{2'b01, 5'd12, 8'h5A, 3,  1'b0, 8'h00, 1};
        vt[6] = '{2'b00, 5'd12, 8'h00, 1,  1'b1, 8'h5A, 0};
        vt[7] = '{2'b00, 5'd13, 8'h00, 1,  1'b1, 8'h3C, 0};
        vt[8] = '{2'b11, 5'd9,  8'hEE, 0,  1'b0, 8'h00, 0};

        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);

        // Reset values while rst is held.
        #1;
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_a", 32'(ram_a), 32'd0);
        chk("rst_d", 32'(ram_d), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write a=5 d=A5 with per-cycle checks of the setup/pulse/hold shape.
        start_req(2'b01, 5'd5, 8'hA5);
        chk("wr_setup_we", 32'(ram_we), 32'd0);
        chk("wr_setup_a", 32'(ram_a), 32'd5);
        chk("wr_setup_d", 32'(ram_d), 32'hA5);
        @(negedge clk);
        chk("wr_pulse_we", 32'(ram_we), 32'd1);
        chk("wr_pulse_a", 32'(ram_a), 32'd5);
        chk("wr_pulse_d", 32'(ram_d), 32'hA5);
        @(negedge clk);
        chk("wr_hold_we", 32'(ram_we), 32'd0);
        chk("wr_hold_a", 32'(ram_a), 32'd5);
        chk("wr_hold_d", 32'(ram_d), 32'hA5);
        chk("wr_hold_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_done_ready", 32'(req_ready), 32'd1);
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);

        // Table-driven transactions.
        for (int i = 0; i < 9; i++) begin
            we_addrs.delete();
            run_txn(vt[i].op, vt[i].a, vt[i].d, bc, gr, gd, wp);
            chk($sformatf("v%0d_busy", i), 32'(bc), 32'(vt[i].busy));
            chk($sformatf("v%0d_rsp", i), 32'(gr), 32'(vt[i].rsp));
            if (vt[i].rsp) chk($sformatf("v%0d_data", i), 32'(gd), 32'(vt[i].rdata));
            chk($sformatf("v%0d_we", i), 32'(wp), 32'(vt[i].we));
            if (vt[i].op == 2'b10) begin
                order_ok = (we_addrs.size() == 32);
                for (int k = 0; k < we_addrs.size(); k++)
                    if (we_addrs[k] != 5'(k)) order_ok = 1'b0;
                chk($sformatf("v%0d_fill_order", i), 32'(order_ok), 32'd1);
                chk($sformatf("v%0d_fill_a_end", i), 32'(ram_a), 32'd31);
            end
        end

        // Back-to-back: valid held high, read a=31 then write a=0 d=FF.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 5'd31;
        req_data  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        req_op   = 2'b01;
        req_addr = 5'd0;
        req_data = 8'hFF;
        chk("b2b_rd_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp_data", 32'(rsp_data), 32'h3C);
        chk("b2b_ready_again", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_wr_busy", 32'(busy), 32'd1);
        chk("b2b_wr_a", 32'(ram_a), 32'd0);
        chk("b2b_wr_d", 32'(ram_d), 32'hFF);
        chk("b2b_rsp_cleared", 32'(rsp_valid), 32'd0);
        do_read("b2b_rd0", 5'd0, 8'hFF);

        // Reset during a write pulse drops ram_we immediately.
        start_req(2'b01, 5'd3, 8'h11);
        @(negedge clk);
        chk("mid_pulse_we", 32'(ram_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_a", 32'(ram_a), 32'd0);
        chk("arst_d", 32'(ram_d), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_data", 32'(rsp_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Reset partway through a fill of 3C, during word 10's pulse.
        run_txn(2'b10, 5'd0, 8'hE7, bc, gr, gd, wp);
        run_txn(2'b01, 5'd11, 8'h77, bc, gr, gd, wp);
        start_req(2'b10, 5'd0, 8'h3C);
        guard = 0;
        while (!(ram_we && ram_a == 5'd10) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("fill_reach_w10", 32'(ram_we && ram_a == 5'd10), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("fill_rst_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read("pf_rd0", 5'd0, 8'h3C);
        do_read("pf_rd9", 5'd9, 8'h3C);
        do_read("pf_rd11", 5'd11, 8'h77);
        do_read("pf_rd12", 5'd12, 8'hE7);
        run_txn(2'b01, 5'd20, 8'h99, bc, gr, gd, wp);
        chk("pf_wr_busy", 32'(bc), 32'd3);
        chk("pf_wr_we", 32'(wp), 32'd1);
        do_read("pf_rd20", 5'd20, 8'h99);

        chk("we_width", 32'(width_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
